// File: rtl/led_sequencer.sv
// Multi-channel LED sequencer: a shared prescaler tick drives per-channel
// OFF/ON/BLINK/PULSE state machines, configured over a valid/ready write port.

module led_channel #(
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick,
    input  logic                wr,
    input  logic [1:0]          mode_in,
    input  logic [PERIOD_W-1:0] period_in,
    output logic                lit,
    output logic                busy
);
    typedef enum logic [1:0] {OFF = 2'd0, ON = 2'd1, BLINK = 2'd2, PULSE = 2'd3} mode_t;

    mode_t               mode;
    logic [PERIOD_W-1:0] period;
    logic [PERIOD_W-1:0] count;
    logic                last;

    assign last = (count == period - PERIOD_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode   <= OFF;
            period <= PERIOD_W'(1);
            count  <= '0;
            lit    <= 1'b0;
            busy   <= 1'b0;
        end else if (wr) begin
            // a write always wins over a tick landing in the same cycle
            mode   <= mode_t'(mode_in);
            period <= (period_in == '0) ? PERIOD_W'(1) : period_in;
            count  <= '0;
            lit    <= (mode_t'(mode_in) != OFF);
            busy   <= (mode_t'(mode_in) == PULSE);
        end else if (tick) begin
            case (mode)
                BLINK: begin
                    if (last) begin
                        lit   <= ~lit;
                        count <= '0;
                    end else begin
                        count <= count + PERIOD_W'(1);
                    end
                end
                PULSE: begin
                    if (last) begin
                        lit   <= 1'b0;
                        busy  <= 1'b0;
                        mode  <= OFF;
                        count <= '0;
                    end else begin
                        count <= count + PERIOD_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

module led_sequencer #(
    parameter int CLK_HZ     = 75_000_000,
    parameter int TICK_HZ    = 1000,
    parameter int CHANNELS   = 4,
    parameter int PERIOD_W   = 16,
    parameter int ACTIVE_LOW = 1,
    localparam int CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CW-1:0]       cfg_chan,
    input  logic [1:0]          cfg_mode,
    input  logic [PERIOD_W-1:0] cfg_period,
    output logic                tick,
    output logic [CHANNELS-1:0] busy,
    output logic [CHANNELS-1:0] led
);
    localparam int   DIV = CLK_HZ / TICK_HZ;
    localparam int   PW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic AL  = (ACTIVE_LOW != 0);

    if (DIV < 2) begin : g_bad_div
        $error("led_sequencer: CLK_HZ / TICK_HZ must be at least 2");
    end

    logic [PW-1:0]       presc;
    logic [CHANNELS-1:0] lit;
    logic                accept;

    assign accept = cfg_valid && cfg_ready;

    // tick is registered so it is high exactly while presc == DIV-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc     <= '0;
            tick      <= 1'b0;
            cfg_ready <= 1'b0;
        end else begin
            presc     <= (presc == PW'(DIV - 1)) ? '0 : presc + PW'(1);
            tick      <= (presc == PW'(DIV - 2));
            cfg_ready <= 1'b1;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        led_channel #(.PERIOD_W(PERIOD_W)) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .tick      (tick),
            .wr        (accept && (cfg_chan == CW'(i))),
            .mode_in   (cfg_mode),
            .period_in (cfg_period),
            .lit       (lit[i]),
            .busy      (busy[i])
        );
    end

    assign led = lit ^ {CHANNELS{AL}};
endmodule
